// File: rtl/scale_ctrl_pkg.sv
// Shared types and constants for the 4:5 down-scaler frame control path.
package scale_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  localparam int SCALE_PIPE_DEPTH = 4;
  localparam int MIN_DIM          = 2;

endpackage

// File: rtl/scale_frame_sequencer_raster_counter.sv
// Raster x/y position counter with synchronous clear; flags the last column and last pixel.
module raster_counter #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] width,
  input  logic [W-1:0] height,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         last_col,
  output logic         last_pixel
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] x_q, x_d;
  logic [W-1:0] y_q, y_d;

  assign x = x_q;
  assign y = y_q;

  // Next position: clear wins, otherwise advance on enable and wrap at the row end.
  always_comb begin
    last_col   = (x_q == (width - ONE));
    last_pixel = last_col && (y_q == (height - ONE));
    x_d        = x_q;
    y_d        = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (en) begin
      if (last_col) begin
        x_d = '0;
        y_d = y_q + ONE;
      end else begin
        x_d = x_q + ONE;
        y_d = y_q;
      end
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/scale_frame_sequencer.sv
// Frame controller for the 4:5 bilinear down-scaler: feeds a clean raster, drains the
// scaler pipeline and counts scaled output pixels.
module scale_frame_sequencer
  import scale_ctrl_pkg::*;
#(
  parameter int LUMA_BITS  = 8,
  parameter int COORD_BITS = 12,
  parameter int PIPE_DEPTH = SCALE_PIPE_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [COORD_BITS-1:0]   cfg_width,
  input  logic [COORD_BITS-1:0]   cfg_height,
  input  logic [LUMA_BITS-1:0]    src_pixel,
  input  logic                    src_valid,
  output logic                    src_ready,
  output logic [COORD_BITS-1:0]   scl_width,
  output logic [LUMA_BITS-1:0]    scl_pixel,
  output logic                    scl_valid,
  output logic [COORD_BITS-1:0]   scl_x,
  output logic [COORD_BITS-1:0]   scl_y,
  input  logic                    scl_out_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic                    cfg_err,
  output logic [2*COORD_BITS-1:0] out_count
);

  localparam int CW = 2 * COORD_BITS;
  localparam int DW = $clog2(PIPE_DEPTH + 2);
  localparam logic [DW-1:0]         DRAIN_LOAD = DW'(PIPE_DEPTH);
  localparam logic [DW-1:0]         DRAIN_ONE  = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]         CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [COORD_BITS-1:0] MIN_DIM_C  = COORD_BITS'(MIN_DIM);

  seq_state_t            state_q, state_d;
  logic [COORD_BITS-1:0] width_q, width_d, height_q, height_d;
  logic [DW-1:0]         drain_q, drain_d;
  logic [LUMA_BITS-1:0]  scl_pixel_q, scl_pixel_d;
  logic [COORD_BITS-1:0] scl_x_q, scl_x_d, scl_y_q, scl_y_d;
  logic [CW-1:0]         out_count_q, out_count_d;
  logic src_ready_q, src_ready_d, scl_valid_q, scl_valid_d, busy_q, busy_d;
  logic done_q, done_d, aborted_q, aborted_d, cfg_err_q, cfg_err_d;

  logic                  beat, frame_end, rc_clr, rc_en, rc_last_col, rc_last_pixel;
  logic [COORD_BITS-1:0] rc_x, rc_y;

  assign beat      = src_valid && src_ready_q;
  assign frame_end = beat && rc_last_col && rc_last_pixel;

  raster_counter #(.W(COORD_BITS)) u_raster (
    .clk        (clk),
    .rst_n      (reset),
    .clr        (rc_clr),
    .en         (rc_en),
    .width      (width_q),
    .height     (height_q),
    .x          (rc_x),
    .y          (rc_y),
    .last_col   (rc_last_col),
    .last_pixel (rc_last_pixel)
  );

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    height_d    = height_q;
    drain_d     = drain_q;
    scl_pixel_d = scl_pixel_q;
    scl_x_d     = scl_x_q;
    scl_y_d     = scl_y_q;
    scl_valid_d = 1'b0;
    aborted_d   = aborted_q;
    cfg_err_d   = 1'b0;
    out_count_d = out_count_q;
    rc_clr      = 1'b0;
    rc_en       = 1'b0;

    // Output pixels only count while the scaler can still be emitting this frame.
    if (((state_q == ST_RUN) || (state_q == ST_DRAIN)) && scl_out_valid && (out_count_q != '1)) begin
      out_count_d = out_count_q + CNT_ONE;
    end else begin
      out_count_d = out_count_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start && (cfg_width >= MIN_DIM_C) && (cfg_height >= MIN_DIM_C)) begin
          state_d     = ST_RUN;
          width_d     = cfg_width;
          height_d    = cfg_height;
          aborted_d   = 1'b0;
          out_count_d = '0;
          rc_clr      = 1'b1;
        end else if (start) begin
          cfg_err_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        rc_en = beat;
        if (beat) begin
          scl_pixel_d = src_pixel;
          scl_valid_d = 1'b1;
          scl_x_d     = rc_x;
          scl_y_d     = rc_y;
        end else begin
          scl_valid_d = 1'b0;
        end
        if (abort) begin
          state_d   = ST_DRAIN;
          aborted_d = 1'b1;
          drain_d   = DRAIN_LOAD;
        end else if (frame_end) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q - DRAIN_ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d      = (state_d != ST_IDLE);
    src_ready_d = (state_d == ST_RUN);
    done_d      = (state_d == ST_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      width_q     <= '0;
      height_q    <= '0;
      drain_q     <= '0;
      scl_pixel_q <= '0;
      scl_x_q     <= '0;
      scl_y_q     <= '0;
      out_count_q <= '0;
      src_ready_q <= 1'b0;
      scl_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      height_q    <= height_d;
      drain_q     <= drain_d;
      scl_pixel_q <= scl_pixel_d;
      scl_x_q     <= scl_x_d;
      scl_y_q     <= scl_y_d;
      out_count_q <= out_count_d;
      src_ready_q <= src_ready_d;
      scl_valid_q <= scl_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign src_ready = src_ready_q;
  assign scl_width = width_q;
  assign scl_pixel = scl_pixel_q;
  assign scl_valid = scl_valid_q;
  assign scl_x     = scl_x_q;
  assign scl_y     = scl_y_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign cfg_err   = cfg_err_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_scale_frame_sequencer.sv
// Self-checking bench: random pixels and gaps, raster/latency/count model, and a 4:5 scaler stand-in.
module tb_scale_frame_sequencer;

  localparam int LB = 8;
  localparam int CB = 12;
  localparam int PD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CB-1:0] cfg_width = '0;
  logic [CB-1:0] cfg_height = '0;
  logic [LB-1:0] src_pixel = '0;
  logic          src_valid = 1'b0;
  logic          src_ready;
  logic [CB-1:0] scl_width;
  logic [LB-1:0] scl_pixel;
  logic          scl_valid;
  logic [CB-1:0] scl_x;
  logic [CB-1:0] scl_y;
  logic          scl_out_valid;
  logic          busy, done, aborted, cfg_err;
  logic [2*CB-1:0] out_count;

  int n_tests = 0;
  int n_fail  = 0;

  scale_frame_sequencer #(.LUMA_BITS(LB), .COORD_BITS(CB), .PIPE_DEPTH(PD)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .src_pixel(src_pixel), .src_valid(src_valid), .src_ready(src_ready),
    .scl_width(scl_width), .scl_pixel(scl_pixel), .scl_valid(scl_valid),
    .scl_x(scl_x), .scl_y(scl_y), .scl_out_valid(scl_out_valid),
    .busy(busy), .done(done), .aborted(aborted), .cfg_err(cfg_err),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  // 4:5 bilinear scaler stand-in: an input position yields an output when floor(4p/5) steps.
  function automatic bit emits(input int p);
    if (p == 0) return 1'b1;
    return ((4 * p) / 5) != ((4 * (p - 1)) / 5);
  endfunction

  function automatic int exp_count(input int w, input int h);
    return (((w - 1) * 4) / 5 + 1) * (((h - 1) * 4) / 5 + 1);
  endfunction

  logic [PD-1:0] scl_pipe;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) scl_pipe <= '0;
    else scl_pipe <= {scl_pipe[PD-2:0], scl_valid && emits(int'(scl_x)) && emits(int'(scl_y))};
  end
  assign scl_out_valid = scl_pipe[PD-1];

  task automatic do_start(input int w, input int h);
    start      = 1'b1;
    cfg_width  = CB'(w);
    cfg_height = CB'(h);
    @(negedge clk);
    start      = 1'b0;
    cfg_width  = CB'($urandom);
    cfg_height = CB'($urandom);
  endtask

  // Drives one frame and checks raster, handshake and completion timing cycle by cycle.
  task automatic run_frame(input int w, input int h, input int gap_mode, input int abort_at,
                           input bit abort_beat, input bit poke, output int seen_valid);
    int k, end_cyc, px, py;
    bit running, prev_acc, acc, fin, exp_ab;
    logic [LB-1:0] ppix;
    k = 0; end_cyc = 0; px = 0; py = 0; ppix = '0;
    running = 1'b1; prev_acc = 1'b0; fin = 1'b0; exp_ab = 1'b0; seen_valid = 0;
    do_start(w, h);
    for (int cyc = 0; cyc < 4 * w * h + 60; cyc++) begin
      n_tests++;
      if (src_ready !== running) begin
        n_fail++; $display("FAIL src_ready cyc=%0d got %b want %b", cyc, src_ready, running);
      end
      n_tests++;
      if (busy !== 1'b1 || scl_width !== CB'(w)) begin
        n_fail++; $display("FAIL busy_width cyc=%0d got busy=%b width=%0d want 1/%0d", cyc, busy, scl_width, w);
      end
      n_tests++;
      if (scl_valid !== prev_acc || cfg_err !== 1'b0) begin
        n_fail++; $display("FAIL scl_valid cyc=%0d got %b cfg_err=%b want %b/0", cyc, scl_valid, cfg_err, prev_acc);
      end
      if (scl_valid === 1'b1) seen_valid++;
      if (prev_acc) begin
        n_tests++;
        if (scl_x !== CB'(px) || scl_y !== CB'(py) || scl_pixel !== ppix) begin
          n_fail++;
          $display("FAIL beat cyc=%0d got (%0d,%0d) pix %h want (%0d,%0d) pix %h",
                   cyc, scl_x, scl_y, scl_pixel, px, py, ppix);
        end
      end
      if (done === 1'b1) begin
        fin = 1'b1;
        n_tests++;
        if (running || (cyc - end_cyc) != PD + 2 || aborted !== exp_ab) begin
          n_fail++;
          $display("FAIL done cyc=%0d latency %0d aborted %b want latency %0d aborted %b",
                   cyc, cyc - end_cyc, aborted, PD + 2, exp_ab);
        end
        break;
      end
      src_valid = 1'b0; abort = 1'b0; start = 1'b0;
      if (running) begin
        case (gap_mode)
          0: src_valid = 1'b1;
          1: src_valid = ((cyc % 2) == 0);
          default: src_valid = 1'($urandom_range(0, 1));
        endcase
        src_pixel = LB'($urandom);
        if (poke && cyc == 3) begin
          start = 1'b1; cfg_width = CB'(3); cfg_height = CB'(3);
        end
        if (abort_at >= 0 && k == abort_at) begin
          abort = 1'b1; src_valid = abort_beat; exp_ab = 1'b1;
        end
      end
      acc = src_valid && running;
      if (acc) begin
        px = k % w; py = k / w; ppix = src_pixel; k++;
      end
      if ((acc && k == w * h) || abort) begin
        running = 1'b0; end_cyc = cyc;
      end
      prev_acc = acc;
      @(negedge clk);
    end
    src_valid = 1'b0; abort = 1'b0; start = 1'b0;
    n_tests++;
    if (!fin) begin
      n_fail++; $display("FAIL timeout w=%0d h=%0d got no done want done", w, h);
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || src_ready !== 1'b0 || aborted !== exp_ab) begin
      n_fail++;
      $display("FAIL post_done got busy=%b done=%b ready=%b aborted=%b want 0/0/0/%b",
               busy, done, src_ready, aborted, exp_ab);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({src_ready, scl_valid, busy, done, aborted, cfg_err} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags got %b want 000000", {src_ready, scl_valid, busy, done, aborted, cfg_err});
    end
    n_tests++;
    if (scl_width !== '0 || scl_pixel !== '0 || scl_x !== '0 || scl_y !== '0 || out_count !== '0) begin
      n_fail++; $display("FAIL reset_data got w=%0d x=%0d y=%0d cnt=%0d want 0", scl_width, scl_x, scl_y, out_count);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_frame(input int w, input int h, input int gap_mode);
    int seen;
    run_frame(w, h, gap_mode, -1, 1'b0, 1'b0, seen);
    n_tests++;
    if (seen != w * h || out_count !== (2*CB)'(exp_count(w, h))) begin
      n_fail++;
      $display("FAIL frame_%0dx%0d got beats=%0d count=%0d want %0d/%0d", w, h, seen, out_count, w * h, exp_count(w, h));
    end
  endtask

  task automatic test_cfg_err(input int w, input int h);
    do_start(w, h);
    n_tests++;
    if (cfg_err !== 1'b1 || busy !== 1'b0 || src_ready !== 1'b0) begin
      n_fail++; $display("FAIL cfg_err_pulse %0dx%0d got err=%b busy=%b ready=%b want 1/0/0", w, h, cfg_err, busy, src_ready);
    end
    @(negedge clk);
    n_tests++;
    if (cfg_err !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL cfg_err_end got err=%b busy=%b want 0/0", cfg_err, busy);
    end
  endtask

  task automatic test_abort(input int at, input bit with_beat, input int gap_mode);
    int seen;
    run_frame(10, 10, gap_mode, at, with_beat, 1'b0, seen);
    n_tests++;
    if (seen != at + (with_beat ? 1 : 0)) begin
      n_fail++; $display("FAIL abort_beats got %0d want %0d", seen, at + (with_beat ? 1 : 0));
    end
  endtask

  task automatic test_reset_mid_run;
    do_start(8, 8);
    src_valid = 1'b1;
    repeat (5) begin
      src_pixel = LB'($urandom);
      @(negedge clk);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({src_ready, scl_valid, busy, done, aborted, cfg_err} !== 6'b0 || scl_width !== '0 ||
        scl_x !== '0 || scl_y !== '0 || scl_pixel !== '0 || out_count !== '0) begin
      n_fail++;
      $display("FAIL async_reset got flags=%b width=%0d x=%0d y=%0d want all 0",
               {src_ready, scl_valid, busy, done, aborted, cfg_err}, scl_width, scl_x, scl_y);
    end
    src_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    test_full_frame(5, 5, 0);
  endtask

  task automatic test_start_ignored;
    int seen;
    run_frame(9, 4, 0, -1, 1'b0, 1'b1, seen);
    n_tests++;
    if (seen != 36 || out_count !== (2*CB)'(exp_count(9, 4))) begin
      n_fail++; $display("FAIL start_ignored got beats=%0d count=%0d want 36/%0d", seen, out_count, exp_count(9, 4));
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++) begin
      test_full_frame(int'($urandom_range(2, 13)), int'($urandom_range(2, 13)), 2);
    end
  endtask

  initial begin
    test_reset;
    test_full_frame(5, 5, 0);
    test_full_frame(6, 2, 1);
    test_full_frame(2, 2, 2);
    test_cfg_err(1, 5);
    test_cfg_err(5, 0);
    test_abort(7, 1'b0, 0);
    test_abort(3, 1'b1, 2);
    test_reset_mid_run;
    test_start_ignored;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scale_frame_sequencer.md
# scale_frame_sequencer

Frame-level controller for the 4:5 bilinear down-scaler. It accepts a start command with frame dimensions and pulls a ready/valid pixel stream from the upstream source. It drives the scaler's `in_pixel`/`in_valid`/`in_x`/`in_y`/`r_width` with a correct raster, drains the scaler pipeline and counts scaled pixels. It then signals frame completion to the host-side sequencer.

## Interface
- `LUMA_BITS`, 8: pixel width.
- `COORD_BITS`, 12: coordinate / dimension width.
- `PIPE_DEPTH`, 4: cycles from scaler `in_valid` to scaler `out_valid`.
- `clk` in 1: sole clock; everything is rising-edge.
- `reset` in 1: asynchronous, active-low. Clears all state and outputs.
- `start` in 1: frame request. Sampled only in IDLE.
- `abort` in 1: terminates the current frame. Sampled only in RUN.
- `cfg_width`, `cfg_height` in COORD_BITS: frame dimensions, sampled with `start`.
- `src_pixel` in LUMA_BITS, `src_valid` in 1, `src_ready` out 1: upstream stream.
- `scl_width` out COORD_BITS: drives scaler `r_width`.
- `scl_pixel` out LUMA_BITS, `scl_valid` out 1, `scl_x`, `scl_y` out COORD_BITS: drive the scaler inputs.
- `scl_out_valid` in 1: scaler `out_valid`.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle completion pulse.
- `aborted` out 1: valid with `done`. Set when the frame ended early.
- `cfg_err` out 1: one-cycle pulse when a start is rejected.
- `out_count` out 2*COORD_BITS: number of scaled pixels in the last frame.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - `src_ready`=0.
  - On `start`, with `cfg_width`≥2 and `cfg_height`≥2: latch both dimensions (`scl_width` ← `cfg_width`), clear x/y/`out_count`, go to RUN.
  - On `start` with either dimension <2: pulse `cfg_err`, stay in IDLE.
- **RUN**
  - `src_ready`=1 (Moore, from state only).
  - Each accepted beat (`src_valid`&&`src_ready`) is registered:
    - `scl_pixel` ← `src_pixel`, `scl_valid` ← 1.
    - `scl_x`/`scl_y` ← current x/y.
    - x advances; it wraps 0 at width-1, and y then increments.
  - First beat of a frame always carries (0,0). This resynchronises the scaler's mod-5 counters.
  - Accepting the beat at (width-1, height-1) moves to DRAIN.
  - `abort` moves to DRAIN the same cycle, with `aborted` latched. If abort coincides with an accepted beat, the beat is still forwarded.
- **DRAIN**
  - `src_ready`=0.
  - Lasts exactly PIPE_DEPTH+1 cycles (down-counter), then go to DONE.
- **DONE**
  - `done`=1 for one cycle, then IDLE.
  - `aborted` and `out_count` are held until the next accepted start.
- `scl_valid` is 0 in every cycle without an accepted beat in the previous cycle.
- `out_count` increments on every `scl_out_valid` in RUN and DRAIN. It saturates at all-ones.
- `scl_width` holds its value from the start until the next accepted start. It must never change mid-frame.
- Full frame, non-aborted: `out_count` = ((W-1)*4/5+1)*((H-1)*4/5+1).

## Timing
- Reset values: `src_ready`, `scl_valid`, `busy`, `done`, `aborted`, `cfg_err` = 0; `scl_*` data/coords, `scl_width`, `out_count` = 0; state = IDLE.
- Latencies:
  - Accepted `start` → `busy`=1 and `src_ready`=1 next cycle.
  - Accepted beat at cycle N → `scl_valid` at N+1.
  - Last beat at N → DRAIN at N+1, `done` at N+PIPE_DEPTH+2.
- Back-pressure gaps (`src_valid`=0) insert `scl_valid`=0 bubbles. Coordinates do not advance during gaps.
- `start` while busy is ignored. `abort` outside RUN is ignored.
- `reset` asserted mid-frame returns to IDLE immediately with no `done`. The scaler is reset by the same net.

## Structure
- Package `scale_ctrl_pkg`:
  - State enum `seq_state_t`.
  - `SCALE_PIPE_DEPTH` = 4.
  - Minimum dimension constant = 2.
- Sub-module `raster_counter`: x/y counter with enable, clear and width/height compare. Outputs `last_col` and `last_pixel`. Reusable by other stream stages.

## Test plan
- 5×5 frame, `src_valid` held 1, real scaler attached → 25 beats with coords (0,0)…(4,4), `out_count`=16, `done` 6 cycles after the last beat, `aborted`=0.
- 6×2 frame with `src_valid` toggling 1,0 → coords advance only on accepted beats, `out_count`=5.
- `start` with `cfg_width`=1 → `cfg_err` pulse, `busy` stays 0, `src_ready` stays 0.
- `abort` after 7 beats of a 10×10 frame → exactly 7 `scl_valid`, then `done`=1 with `aborted`=1 after PIPE_DEPTH+1 drain cycles.
- `reset` low mid-RUN → all outputs 0 asynchronously. A following 5×5 start then completes normally with `out_count`=16.
- `start` pulsed during RUN with different dimensions → ignored, `scl_width` unchanged.
